// File: rtl/vga_pkg.sv
// Shared video constants and types for the sprite overlay block.
// The active area, colour width and pixel coordinate widths live here.
package vga_pkg;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int COLOR_W     = 12;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int MAX_SPRITES = 8;

    typedef logic [COLOR_W-1:0] rgb_t;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic multi_hit(input logic [MAX_SPRITES-1:0] hits);
        return (hits & (hits - MAX_SPRITES'(1))) != '0;
    endfunction

endpackage

// File: rtl/sprite_overlay_if.sv
// Pixel-stream bundle between the timing/background source and the sprite overlay.
// The master drives the pixel position and move requests; the slave returns the composited pixel.
interface sprite_overlay_if #(
    parameter int NUM_SPRITES = 2
);
    import vga_pkg::*;

    logic                   screen_end;
    logic                   active;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    rgb_t                   bg_color;
    logic [NUM_SPRITES-1:0] move_up;
    logic [NUM_SPRITES-1:0] move_down;
    logic [NUM_SPRITES-1:0] move_left;
    logic [NUM_SPRITES-1:0] move_right;
    rgb_t                   rgb;
    logic [NUM_SPRITES-1:0] sprite_hit;
    logic                   collision;

    modport master (
        output screen_end, active, x, y, bg_color,
        output move_up, move_down, move_left, move_right,
        input  rgb, sprite_hit, collision
    );

    modport slave (
        input  screen_end, active, x, y, bg_color,
        input  move_up, move_down, move_left, move_right,
        output rgb, sprite_hit, collision
    );

endinterface

// File: rtl/sprite_pos.sv
// One sprite: top-left position register, per-frame move with clamp or wrap,
// and the combinational test of whether the current pixel lies inside the sprite.
module sprite_pos
    import vga_pkg::*;
#(
    parameter int SPRITE_SIZE = 100,
    parameter int STEP        = 1,
    parameter int WRAP_MODE   = 0,
    parameter int X_LIM       = 540,
    parameter int Y_LIM       = 380,
    parameter int INIT_X      = 0,
    parameter int INIT_Y      = 190
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick_i,
    input  logic           move_up_i,
    input  logic           move_down_i,
    input  logic           move_left_i,
    input  logic           move_right_i,
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    output logic           hit_o
);

    localparam int XS_W = X_W + 2;
    localparam int YS_W = Y_W + 2;

    localparam logic signed [XS_W-1:0] X_STEP_S = XS_W'(STEP);
    localparam logic signed [YS_W-1:0] Y_STEP_S = YS_W'(STEP);
    localparam logic signed [XS_W-1:0] X_LIM_S  = XS_W'(X_LIM);
    localparam logic signed [YS_W-1:0] Y_LIM_S  = YS_W'(Y_LIM);
    localparam logic signed [XS_W-1:0] X_SPAN_S = XS_W'(X_LIM + 1);
    localparam logic signed [YS_W-1:0] Y_SPAN_S = YS_W'(Y_LIM + 1);
    localparam logic [X_W:0]           SIZE_X   = (X_W + 1)'(SPRITE_SIZE);
    localparam logic [Y_W:0]           SIZE_Y   = (Y_W + 1)'(SPRITE_SIZE);

    logic [X_W-1:0]         xtl_q, xtl_d;
    logic [Y_W-1:0]         ytl_q, ytl_d;
    logic signed [XS_W-1:0] x_sum;
    logic signed [YS_W-1:0] y_sum;

    // Two guard bits keep a step past either edge visible as negative or above-limit.
    always_comb begin
        y_sum = $signed({2'b00, ytl_q});
        x_sum = $signed({2'b00, xtl_q});
        if (move_up_i)    y_sum = y_sum - Y_STEP_S;
        if (move_down_i)  y_sum = y_sum + Y_STEP_S;
        if (move_left_i)  x_sum = x_sum - X_STEP_S;
        if (move_right_i) x_sum = x_sum + X_STEP_S;

        if (WRAP_MODE != 0) begin
            if (x_sum[XS_W-1])        x_sum = x_sum + X_SPAN_S;
            else if (x_sum > X_LIM_S) x_sum = x_sum - X_SPAN_S;
            if (y_sum[YS_W-1])        y_sum = y_sum + Y_SPAN_S;
            else if (y_sum > Y_LIM_S) y_sum = y_sum - Y_SPAN_S;
        end else begin
            if (x_sum[XS_W-1])        x_sum = '0;
            else if (x_sum > X_LIM_S) x_sum = X_LIM_S;
            if (y_sum[YS_W-1])        y_sum = '0;
            else if (y_sum > Y_LIM_S) y_sum = Y_LIM_S;
        end

        xtl_d = frame_tick_i ? x_sum[X_W-1:0] : xtl_q;
        ytl_d = frame_tick_i ? y_sum[Y_W-1:0] : ytl_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            xtl_q <= X_W'(INIT_X);
            ytl_q <= Y_W'(INIT_Y);
        end else begin
            xtl_q <= xtl_d;
            ytl_q <= ytl_d;
        end
    end

    assign hit_o = ({1'b0, x_i} >= {1'b0, xtl_q}) && ({1'b0, x_i} < ({1'b0, xtl_q} + SIZE_X)) &&
                   ({1'b0, y_i} >= {1'b0, ytl_q}) && ({1'b0, y_i} < ({1'b0, ytl_q} + SIZE_Y));

endmodule

// File: rtl/sprite_overlay.sv
// Overlays NUM_SPRITES movable squares on a background pixel stream and reports
// whether any two sprites overlapped on a visible pixel during the previous frame.
module sprite_overlay #(
    parameter int NUM_SPRITES = 2,
    parameter int SPRITE_SIZE = 100,
    parameter int STEP        = 1,
    parameter int WRAP_MODE   = 0,
    parameter int H_RES       = vga_pkg::H_RES,
    parameter int V_RES       = vga_pkg::V_RES,
    parameter logic [NUM_SPRITES*vga_pkg::COLOR_W-1:0] SPRITE_COLORS = {NUM_SPRITES{12'hF00}}
) (
    input  logic            clk,
    input  logic            reset,
    sprite_overlay_if.slave bus
);
    import vga_pkg::*;

    localparam int X_LIM = H_RES - SPRITE_SIZE;
    localparam int Y_LIM = V_RES - SPRITE_SIZE;

    logic                   screen_end_q;
    logic                   frame_tick;
    logic [NUM_SPRITES-1:0] hit_raw;
    logic [NUM_SPRITES-1:0] hit_d, hit_q;
    rgb_t                   rgb_d, rgb_q;
    logic                   overlap_d, overlap_q;
    logic                   acc_d, acc_q;
    logic                   collision_d, collision_q;

    assign frame_tick = bus.screen_end & ~screen_end_q;

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
            sprite_pos #(
                .SPRITE_SIZE (SPRITE_SIZE),
                .STEP        (STEP),
                .WRAP_MODE   (WRAP_MODE),
                .X_LIM       (X_LIM),
                .Y_LIM       (Y_LIM),
                .INIT_X      ((gi * SPRITE_SIZE) % (X_LIM + 1)),
                .INIT_Y      (Y_LIM / 2)
            ) u_pos (
                .clk          (clk),
                .reset        (reset),
                .frame_tick_i (frame_tick),
                .move_up_i    (bus.move_up[gi]),
                .move_down_i  (bus.move_down[gi]),
                .move_left_i  (bus.move_left[gi]),
                .move_right_i (bus.move_right[gi]),
                .x_i          (bus.x),
                .y_i          (bus.y),
                .hit_o        (hit_raw[gi])
            );
        end
    endgenerate

    // Scanning from the top index down lets the lowest-index hit sprite win.
    always_comb begin
        rgb_d = bus.bg_color;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_raw[i]) rgb_d = SPRITE_COLORS[i*COLOR_W +: COLOR_W];
        end
        hit_d = hit_raw;
        if (!bus.active) begin
            rgb_d = '0;
            hit_d = '0;
        end
        overlap_d = multi_hit(MAX_SPRITES'(hit_d));
    end

    // The overlap flag present on the tick cycle still belongs to the frame being closed.
    always_comb begin
        acc_d       = acc_q | overlap_q;
        collision_d = collision_q;
        if (frame_tick) begin
            collision_d = acc_q | overlap_q;
            acc_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            screen_end_q <= 1'b1;
            rgb_q        <= '0;
            hit_q        <= '0;
            overlap_q    <= 1'b0;
            acc_q        <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            screen_end_q <= bus.screen_end;
            rgb_q        <= rgb_d;
            hit_q        <= hit_d;
            overlap_q    <= overlap_d;
            acc_q        <= acc_d;
            collision_q  <= collision_d;
        end
    end

    assign bus.rgb        = rgb_q;
    assign bus.sprite_hit = hit_q;
    assign bus.collision  = collision_q;

endmodule

// File: tb/tb_sprite_overlay.sv
// Self-checking bench: a clamp instance (STEP=15) and a wrap instance (STEP=1) share one
// stimulus stream and are compared against a position/coverage model kept in plain integers.
module tb_sprite_overlay;
    import vga_pkg::*;

    localparam int   SZ   = 100;
    localparam int   XL   = 640 - SZ;
    localparam int   YL   = 480 - SZ;
    localparam rgb_t COL0 = 12'hF00;
    localparam rgb_t COL1 = 12'h0F0;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           screen_end;
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    rgb_t           bg;
    logic [1:0]     mu, md, ml, mr;

    int checks;
    int failures;
    int px [2][2];
    int py [2][2];
    bit acc [2];
    bit col [2];

    always #5 clk = ~clk;

    sprite_overlay_if #(.NUM_SPRITES(2)) if_c ();
    sprite_overlay_if #(.NUM_SPRITES(2)) if_w ();

    assign if_c.screen_end = screen_end;
    assign if_c.active     = active;
    assign if_c.x          = x;
    assign if_c.y          = y;
    assign if_c.bg_color   = bg;
    assign if_c.move_up    = mu;
    assign if_c.move_down  = md;
    assign if_c.move_left  = ml;
    assign if_c.move_right = mr;
    assign if_w.screen_end = screen_end;
    assign if_w.active     = active;
    assign if_w.x          = x;
    assign if_w.y          = y;
    assign if_w.bg_color   = bg;
    assign if_w.move_up    = mu;
    assign if_w.move_down  = md;
    assign if_w.move_left  = ml;
    assign if_w.move_right = mr;

    sprite_overlay #(
        .NUM_SPRITES(2), .SPRITE_SIZE(SZ), .STEP(15), .WRAP_MODE(0),
        .H_RES(640), .V_RES(480), .SPRITE_COLORS({COL1, COL0})
    ) dut_clamp (
        .clk(clk), .reset(reset_n), .bus(if_c)
    );

    sprite_overlay #(
        .NUM_SPRITES(2), .SPRITE_SIZE(SZ), .STEP(1), .WRAP_MODE(1),
        .H_RES(640), .V_RES(480), .SPRITE_COLORS({COL1, COL0})
    ) dut_wrap (
        .clk(clk), .reset(reset_n), .bus(if_w)
    );

    function automatic int step_of(input int k);
        return (k == 0) ? 15 : 1;
    endfunction

    function automatic int mv(input int p, input bit dec, input bit inc,
                              input int step, input int lim, input bit wrap);
        int r;
        r = p + (inc ? step : 0) - (dec ? step : 0);
        if (wrap) begin
            if (r < 0)        r = r + lim + 1;
            else if (r > lim) r = r - lim - 1;
        end else begin
            if (r < 0)        r = 0;
            else if (r > lim) r = lim;
        end
        return r;
    endfunction

    function automatic bit covers(input int k, input int s, input int xx, input int yy);
        return (xx >= px[k][s]) && (xx < px[k][s] + SZ) && (yy >= py[k][s]) && (yy < py[k][s] + SZ);
    endfunction

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut=%s got=%h exp=%h", tag, (k == 0) ? "clamp" : "wrap", obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                px[k][s] = (s * SZ) % (XL + 1);
                py[k][s] = YL / 2;
            end
            acc[k] = 1'b0;
            col[k] = 1'b0;
        end
    endtask

    task automatic probe(input int xx, input int yy, input bit act);
        rgb_t       e_rgb;
        logic [1:0] e_hit;
        int         xq, yq;
        x      = X_W'(xx);
        y      = Y_W'(yy);
        active = act;
        bg     = rgb_t'($urandom);
        xq     = int'(x);
        yq     = int'(y);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            e_hit = 2'b00;
            for (int s = 0; s < 2; s++) begin
                if (act && covers(k, s, xq, yq)) e_hit[s] = 1'b1;
            end
            if (!act)          e_rgb = 12'h000;
            else if (e_hit[0]) e_rgb = COL0;
            else if (e_hit[1]) e_rgb = COL1;
            else               e_rgb = bg;
            if (e_hit == 2'b11) acc[k] = 1'b1;
            chk("rgb", k, {4'h0, (k == 0) ? if_c.rgb : if_w.rgb}, {4'h0, e_rgb});
            chk("sprite_hit", k, {14'h0, (k == 0) ? if_c.sprite_hit : if_w.sprite_hit}, {14'h0, e_hit});
        end
    endtask

    task automatic probe_all();
        bit a;
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                int xx, yy;
                xx = px[k][s];
                yy = py[k][s];
                probe(xx, yy, 1'b1);
                if (xx > 0) probe(xx - 1, yy, 1'b1);
                if (yy > 0) probe(xx, yy - 1, 1'b1);
                probe(xx + SZ - 1, yy + SZ - 1, 1'b1);
                probe(xx + SZ, yy + SZ - 1, 1'b1);
                probe(xx + SZ - 1, yy + SZ, 1'b1);
            end
        end
        a = ($urandom_range(0, 1) != 0);
        probe($urandom_range(0, 639), $urandom_range(0, 479), a);
    endtask

    // One frame boundary: screen_end high for 'hold' clocks with the given move requests.
    task automatic frame(input logic [1:0] u, input logic [1:0] d, input logic [1:0] l,
                         input logic [1:0] r, input int hold);
        active = 1'b0;
        mu = u; md = d; ml = l; mr = r;
        screen_end = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            col[k] = acc[k];
            acc[k] = 1'b0;
            for (int s = 0; s < 2; s++) begin
                px[k][s] = mv(px[k][s], l[s], r[s], step_of(k), XL, k == 1);
                py[k][s] = mv(py[k][s], u[s], d[s], step_of(k), YL, k == 1);
            end
        end
        repeat (hold - 1) @(posedge clk);
        #1;
        screen_end = 1'b0;
        mu = '0; md = '0; ml = '0; mr = '0;
        @(posedge clk); #1;
        chk("collision", 0, {15'h0, if_c.collision}, {15'h0, col[0]});
        chk("collision", 1, {15'h0, if_w.collision}, {15'h0, col[1]});
    endtask

    task automatic do_reset(input bit se, input logic [1:0] r);
        reset_n = 1'b0;
        screen_end = se;
        mu = '0; md = '0; ml = '0; mr = r;
        active = 1'b1; x = '0; y = Y_W'(190); bg = 12'hABC;
        @(posedge clk); #1;
        model_reset();
        chk("reset_rgb", 0, {4'h0, if_c.rgb}, 16'h0);
        chk("reset_rgb", 1, {4'h0, if_w.rgb}, 16'h0);
        chk("reset_hit", 0, {14'h0, if_c.sprite_hit}, 16'h0);
        chk("reset_hit", 1, {14'h0, if_w.sprite_hit}, 16'h0);
        chk("reset_collision", 0, {15'h0, if_c.collision}, 16'h0);
        chk("reset_collision", 1, {15'h0, if_w.collision}, 16'h0);
        reset_n = 1'b1;
        active = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        screen_end = 1'b1;
        active = 1'b0;
        x = '0; y = '0; bg = '0;
        mu = '0; md = '0; ml = '0; mr = '0;

        // Reset with screen_end already high and moves requested: no update may follow.
        do_reset(1'b1, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        screen_end = 1'b0;
        mr = '0;
        @(posedge clk); #1;
        probe_all();

        // Quiet frame, then sprite 0's corner pixel and a pixel clear of both sprites.
        frame(2'b00, 2'b00, 2'b00, 2'b00, 1);
        probe(0, 190, 1'b1);
        probe(200, 190, 1'b1);
        probe(50, 200, 1'b0);

        // Sprite 0 pushed left at x=0 (clamps / wraps to 540), then back right.
        repeat (3) begin
            frame(2'b00, 2'b00, 2'b01, 2'b00, 1);
            probe_all();
        end
        repeat (3) begin
            frame(2'b00, 2'b00, 2'b00, 2'b01, 1);
            probe_all();
        end

        // Opposite vertical requests cancel; a long screen_end gives a single step.
        frame(2'b11, 2'b11, 2'b00, 2'b00, 1);
        probe_all();
        frame(2'b00, 2'b11, 2'b00, 2'b00, 5);
        probe_all();

        for (int f = 0; f < 20; f++) begin
            frame(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(1, 4));
            probe_all();
        end

        // Bring sprite 1 over sprite 0, report the collision, then separate them.
        do_reset(1'b0, 2'b00);
        repeat (10) frame(2'b00, 2'b00, 2'b10, 2'b00, 1);
        probe(95, 190, 1'b1);
        frame(2'b00, 2'b00, 2'b00, 2'b00, 1);
        repeat (12) frame(2'b00, 2'b00, 2'b00, 2'b10, 1);
        probe_all();
        frame(2'b00, 2'b00, 2'b00, 2'b00, 1);
        frame(2'b00, 2'b00, 2'b00, 2'b00, 1);

        // Overlap seen mid-frame, then reset: the pending overlap must be dropped.
        repeat (10) frame(2'b00, 2'b00, 2'b10, 2'b00, 1);
        probe(95, 190, 1'b1);
        probe(60, 250, 1'b1);
        do_reset(1'b0, 2'b00);
        frame(2'b00, 2'b00, 2'b00, 2'b00, 1);
        probe_all();

        // Long runs into the right, top and bottom edges.
        repeat (40) begin
            frame(2'b00, 2'b00, 2'b00, 2'b01, 1);
            probe_all();
        end
        repeat (15) begin
            frame(2'b11, 2'b00, 2'b00, 2'b00, 1);
            probe_all();
        end
        repeat (30) begin
            frame(2'b00, 2'b11, 2'b00, 2'b00, 1);
            probe_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
